mxv_result_tx: RTL and testbench
================================

# mxv_result_tx

Result-frame transmitter for the MxV accelerator. When the MxV state machine finishes an operation, this block reads the N result words from the result buffer and serializes them into bytes for the UART transmitter. The frame is `FE`, length, data bytes (MSB first), optional checksum, then `EF`. It mirrors the framing the receive path already decodes, and sits between the result buffer/MxV_SM and the UART TX byte interface.

## Interface
- `RES_W`, default 16: width of one result word; must be 16 (two bytes per word).
- `MAX_N`, default 8: maximum vector length.
- `ADDR_W`, default 3: result buffer address width; must satisfy 2^ADDR_W >= MAX_N.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `START`  in  1  one-cycle request from MxV_SM (TRANSMIT_EN); begins a frame.
- `N`  in  4  vector length, sampled on the cycle START is accepted.
- `RES_RD`  out  1  result buffer read strobe.
- `RES_ADDR`  out  ADDR_W  result buffer read address.
- `RES_DATA`  in  RES_W  result word, valid exactly 1 cycle after `RES_RD`.
- `TX_DATA`  out  8  byte to UART TX; held stable from TX_START until TX_DONE.
- `TX_START`  out  1  one-cycle pulse launching `TX_DATA`.
- `TX_DONE`  in  1  one-cycle pulse from UART TX: the current byte is finished.
- `BUSY`  out  1  high from START acceptance through the DONE cycle.
- `DONE`  out  1  one-cycle pulse after TX_DONE of the `EF` byte; drives OP/TX_DONE of MxV_SM.

## Operation
- States:
  - IDLE
  - SEND_HDR (`FE`)
  - SEND_LEN
  - FETCH
  - SEND_HI
  - SEND_LO
  - SEND_CHK (macro only)
  - SEND_TAIL (`EF`)
  - FIN
- Each SEND_x state behaves as follows:
  - Load TX_DATA and pulse TX_START once on entry.
  - Then wait for TX_DONE.
  - Advance on the cycle after TX_DONE.
- IDLE: `START=1` latches `n_q = min(N, MAX_N)`, clears `idx` and the checksum, then goes to SEND_HDR.
- SEND_HDR → SEND_LEN. The LEN byte is `{4'h0, n_q}`.
- SEND_LEN → FETCH if `n_q != 0`, else SEND_CHK/SEND_TAIL.
- FETCH:
  - Assert RES_RD with RES_ADDR=idx for one cycle.
  - The next cycle latches RES_DATA into `word_q`, then goes to SEND_HI.
- SEND_HI sends `word_q[15:8]` → SEND_LO.
- SEND_LO sends `word_q[7:0]` and increments idx:
  - If `idx == n_q-1`, go to SEND_CHK/SEND_TAIL.
  - Otherwise go to FETCH.
- SEND_TAIL → FIN. FIN pulses DONE → IDLE.
- START while BUSY is ignored; no queuing.
- TX_DONE outside a SEND_x wait is ignored.
- N > MAX_N saturates to MAX_N. The LEN byte carries the saturated value.
- Data bytes equal to `FE`/`EF` are sent unescaped; the receiver relies on LEN.
- rst (at any time, including mid-frame):
  - All outputs go to 0 on the next edge (TX_DATA=8'h00, RES_ADDR=0) and the state returns to IDLE.
  - A byte in flight in UART TX is not recalled.

## Timing
- START accepted at cycle 0 → TX_START for `FE` at cycle 1.
- For LEN, CHK and TAIL bytes: TX_DONE at cycle k → next TX_START at k+1.
- For a hi byte: TX_DONE at k → RES_RD at k+1 → RES_DATA latched at k+2 → TX_START at k+3.
- SEND_LO TX_START is issued 1 cycle after the hi byte's TX_DONE.
- DONE is asserted 1 cycle after the `EF` TX_DONE, and BUSY falls in the same cycle.
- A new START is accepted at the earliest on the cycle after DONE.
- Minimum frame length is 3 bytes (N=0) or 4 with checksum. Maximum is 2·MAX_N+3 (+1).

## Configuration
- `MXV_TX_CHECKSUM_EN` defined:
  - SEND_CHK is compiled in between the last data byte (or LEN if N=0) and `EF`.
  - The CHK byte is the XOR of the LEN byte and all data bytes.
- Not defined:
  - SEND_CHK and the checksum register are absent.
  - The transition goes directly to SEND_TAIL.

## Test plan
- N=3, results {0x0004, 0x0102, 0xFFFF}, TX_DONE 10 cycles after each TX_START → bytes `FE 03 00 04 01 02 FF FF EF`. RES_ADDR sequence is 0,1,2 and DONE pulses once.
- Same stimulus with `MXV_TX_CHECKSUM_EN` → `FE 03 00 04 01 02 FF FF 04 EF`.
- N=0 → `FE 00 EF` with no RES_RD assertion. N=12 → LEN byte `08` and 8 words read.
- START pulsed again during data byte 2 → ignored. The frame completes unchanged and exactly one DONE occurs.
- rst asserted while waiting on TX_DONE of byte 4 → next cycle all outputs are 0 and BUSY=0. A fresh START yields a complete frame starting with `FE`.
- TX_DONE delay of 1 cycle; check cycle-exact TX_START spacing:
  - 1 cycle after TX_DONE for header, LEN, lo, CHK and tail bytes.
  - 3 cycles after TX_DONE for hi bytes.
  - A spurious TX_DONE in IDLE has no effect.

Source files
------------

// File: rtl/mxv_result_tx_if.sv
// Bus between MxV_SM/result buffer/UART TX and the result-frame transmitter.
// slave = transmitter side, master = the surrounding system (or a bench).
interface mxv_result_tx_if #(
  parameter int RES_W  = 16,
  parameter int ADDR_W = 3
);
  logic              START;
  logic [3:0]        N;
  logic              RES_RD;
  logic [ADDR_W-1:0] RES_ADDR;
  logic [RES_W-1:0]  RES_DATA;
  logic [7:0]        TX_DATA;
  logic              TX_START;
  logic              TX_DONE;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, N, RES_DATA, TX_DONE,
    input  RES_RD, RES_ADDR, TX_DATA, TX_START, BUSY, DONE
  );

  modport slave (
    input  START, N, RES_DATA, TX_DONE,
    output RES_RD, RES_ADDR, TX_DATA, TX_START, BUSY, DONE
  );
endinterface

// File: rtl/mxv_result_tx.sv
// Serializes N result words into FE,LEN,data(MSB first),[CHK],EF; CHK built only with MXV_TX_CHECKSUM_EN.
// First TX_START 1 cycle after START; each byte stalls until UART TX_DONE; START is ignored while BUSY.
module mxv_result_tx #(
  parameter int RES_W  = 16,
  parameter int MAX_N  = 8,
  parameter int ADDR_W = 3
) (
  input logic            clk,
  input logic            rst,
  mxv_result_tx_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    SEND_HDR,
    SEND_LEN,
    FETCH,
    SEND_HI,
    SEND_LO,
`ifdef MXV_TX_CHECKSUM_EN
    SEND_CHK,
`endif
    SEND_TAIL,
    FIN
  } state_t;

  localparam logic [3:0] MAX_N4 = 4'(MAX_N);

  state_t            r_state;
  logic [3:0]        r_n;
  logic [3:0]        r_idx;
  logic [RES_W-1:0]  r_word;
  logic              r_fetch_ph;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic              r_res_rd;
  logic [ADDR_W-1:0] r_res_addr;
`ifdef MXV_TX_CHECKSUM_EN
  logic [7:0]        r_chk;
`endif

  state_t            w_state_nxt;
  state_t            w_after_data;
  logic              w_accept;
  logic              w_last;
  logic [3:0]        w_n_sat;
  logic [3:0]        w_idx_nxt;
  logic [7:0]        w_tx_data_nxt;
  logic              w_tx_start_nxt;
  logic              w_res_rd_nxt;
  logic [ADDR_W-1:0] w_res_addr_nxt;

  assign w_accept = (r_state == IDLE) && bus.START;
  assign w_n_sat  = (bus.N > MAX_N4) ? MAX_N4 : bus.N;
  assign w_last   = (r_idx == r_n - 4'd1);
`ifdef MXV_TX_CHECKSUM_EN
  assign w_after_data = SEND_CHK;
`else
  assign w_after_data = SEND_TAIL;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // SEND_x states only move on TX_DONE; FETCH takes two cycles (read, then capture).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (bus.START)   w_state_nxt = SEND_HDR;
      SEND_HDR:  if (bus.TX_DONE) w_state_nxt = SEND_LEN;
      SEND_LEN:  if (bus.TX_DONE) w_state_nxt = (r_n != 4'd0) ? FETCH : w_after_data;
      FETCH:     if (r_fetch_ph)  w_state_nxt = SEND_HI;
      SEND_HI:   if (bus.TX_DONE) w_state_nxt = SEND_LO;
      SEND_LO:   if (bus.TX_DONE) w_state_nxt = w_last ? w_after_data : FETCH;
`ifdef MXV_TX_CHECKSUM_EN
      SEND_CHK:  if (bus.TX_DONE) w_state_nxt = SEND_TAIL;
`endif
      SEND_TAIL: if (bus.TX_DONE) w_state_nxt = FIN;
      FIN:                        w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Byte, strobe and read address are produced on the edge that enters the state.
  always_comb begin
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_res_rd_nxt   = 1'b0;
    w_res_addr_nxt = r_res_addr;
    w_idx_nxt      = r_idx;
    if (w_accept)
      w_idx_nxt = 4'd0;
    else if (r_state == SEND_LO && bus.TX_DONE)
      w_idx_nxt = r_idx + 4'd1;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        SEND_HDR:  begin w_tx_start_nxt = 1'b1; w_tx_data_nxt = 8'hFE; end
        SEND_LEN:  begin w_tx_start_nxt = 1'b1; w_tx_data_nxt = {4'h0, r_n}; end
        FETCH:     begin w_res_rd_nxt = 1'b1; w_res_addr_nxt = w_idx_nxt[ADDR_W-1:0]; end
        SEND_HI:   begin w_tx_start_nxt = 1'b1; w_tx_data_nxt = bus.RES_DATA[15:8]; end
        SEND_LO:   begin w_tx_start_nxt = 1'b1; w_tx_data_nxt = r_word[7:0]; end
`ifdef MXV_TX_CHECKSUM_EN
        SEND_CHK:  begin w_tx_start_nxt = 1'b1; w_tx_data_nxt = r_chk; end
`endif
        SEND_TAIL: begin w_tx_start_nxt = 1'b1; w_tx_data_nxt = 8'hEF; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n        <= 4'd0;
      r_idx      <= 4'd0;
      r_word     <= '0;
      r_fetch_ph <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_res_rd   <= 1'b0;
      r_res_addr <= '0;
`ifdef MXV_TX_CHECKSUM_EN
      r_chk      <= 8'h00;
`endif
    end else begin
      r_idx      <= w_idx_nxt;
      r_fetch_ph <= (r_state == FETCH) && !r_fetch_ph;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_res_rd   <= w_res_rd_nxt;
      r_res_addr <= w_res_addr_nxt;
      if (w_accept)
        r_n <= w_n_sat;
      if (r_state == FETCH && r_fetch_ph)
        r_word <= bus.RES_DATA;
`ifdef MXV_TX_CHECKSUM_EN
      if (w_accept)
        r_chk <= 8'h00;
      else if (w_tx_start_nxt && (w_state_nxt == SEND_LEN || w_state_nxt == SEND_HI ||
                                  w_state_nxt == SEND_LO))
        r_chk <= r_chk ^ w_tx_data_nxt;
`endif
    end
  end

  assign bus.TX_DATA  = r_tx_data;
  assign bus.TX_START = r_tx_start;
  assign bus.RES_RD   = r_res_rd;
  assign bus.RES_ADDR = r_res_addr;
  assign bus.BUSY     = (r_state != IDLE);
  assign bus.DONE     = (r_state == FIN);

endmodule

// File: tb/tb_mxv_result_tx.sv
// Directed bench for mxv_result_tx: scoreboard of expected bytes/gaps and read addresses, UART and buffer models.
module tb_mxv_result_tx;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mxv_result_tx_if bus ();
  mxv_result_tx dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        eq[$];
  int          aq[$];
  exp_t        e_cur;
  logic [15:0] mem[8];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ref_cyc = 0;
  int          cnt = 0;
  int          tx_delay = 10;
  int          n_bytes = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  logic        uart_done = 1'b0;
  logic        inj_done = 1'b0;

  assign bus.TX_DONE = uart_done | inj_done;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result buffer: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.RES_RD) bus.RES_DATA <= mem[bus.RES_ADDR];
  end

  // UART model plus output monitor; gaps are measured from START acceptance or the last UART TX_DONE.
  always @(negedge clk) begin
    if (cnt > 0) begin
      cnt       <= cnt - 1;
      uart_done <= (cnt == 1);
      if (cnt == 1) ref_cyc <= cyc;
    end else begin
      uart_done <= 1'b0;
    end
    if (bus.START && !bus.BUSY && !rst) ref_cyc <= cyc;
    if (bus.TX_START) begin
      n_bytes <= n_bytes + 1;
      cnt     <= tx_delay;
      if (eq.size() == 0) begin
        check("extra_byte", eq.size(), 1);
      end else begin
        e_cur = eq.pop_front();
        check("tx_byte", bus.TX_DATA, e_cur.b);
        check("tx_gap", cyc - ref_cyc, e_cur.gap);
      end
    end
    if (bus.RES_RD) begin
      rd_cnt <= rd_cnt + 1;
      if (aq.size() == 0) check("extra_rd", aq.size(), 1);
      else                check("res_addr", bus.RES_ADDR, aq.pop_front());
    end
    if (bus.DONE) begin
      done_cnt <= done_cnt + 1;
      check("done_gap", cyc - ref_cyc, 1);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(int n);
    int         nn;
    logic [7:0] chk;
    nn  = (n > 8) ? 8 : n;
    chk = 8'(nn);
    eq.push_back('{8'hFE, 1});
    eq.push_back('{8'(nn), 1});
    for (int i = 0; i < nn; i++) begin
      eq.push_back('{mem[i][15:8], 3});
      eq.push_back('{mem[i][7:0], 1});
      aq.push_back(i);
      chk = chk ^ mem[i][15:8] ^ mem[i][7:0];
    end
`ifdef MXV_TX_CHECKSUM_EN
    eq.push_back('{chk, 1});
`endif
    eq.push_back('{8'hEF, 1});
  endtask

  task automatic pulse_start(int n);
    bus.N     = 4'(n);
    bus.START = 1'b1;
    tick(1);
    bus.START = 1'b0;
  endtask

  task automatic wait_bytes(int target);
    for (int i = 0; i < 2000 && n_bytes < target; i++) @(negedge clk);
    check("bytes_reached", n_bytes >= target, 1);
  endtask

  task automatic wait_done(int prev);
    for (int i = 0; i < 3000 && done_cnt == prev; i++) @(negedge clk);
    tick(4);
    check("done_once", done_cnt, prev + 1);
    check("bytes_all_sent", eq.size(), 0);
    check("reads_all_done", aq.size(), 0);
    check("busy_after", bus.BUSY, 0);
  endtask

  task automatic run_frame(int n, int d);
    int prev;
    tx_delay = d;
    prev     = done_cnt;
    push_frame(n);
    pulse_start(n);
    wait_done(prev);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_tx_start"}, bus.TX_START, 0);
    check({tag, "_tx_data"}, bus.TX_DATA, 0);
    check({tag, "_res_rd"}, bus.RES_RD, 0);
    check({tag, "_res_addr"}, bus.RES_ADDR, 0);
    check({tag, "_busy"}, bus.BUSY, 0);
    check({tag, "_done"}, bus.DONE, 0);
  endtask

  initial begin
    int base;
    int prev;
    int prev_rd;
    bus.START = 1'b0;
    bus.N     = 4'd0;
    mem[0] = 16'h0004; mem[1] = 16'h0102; mem[2] = 16'hFFFF; mem[3] = 16'hFEEF;
    mem[4] = 16'h1234; mem[5] = 16'hEFFE; mem[6] = 16'h00FF; mem[7] = 16'h8001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Stray TX_DONE while idle must not launch anything.
    tick(2);
    inj_done = 1'b1;
    tick(1);
    inj_done = 1'b0;
    tick(5);
    check("idle_no_bytes", n_bytes, 0);
    check("idle_busy", bus.BUSY, 0);

    run_frame(3, 10);

    prev_rd = rd_cnt;
    run_frame(0, 10);
    check("n0_no_reads", rd_cnt - prev_rd, 0);

    prev_rd = rd_cnt;
    run_frame(12, 1);
    check("n12_reads", rd_cnt - prev_rd, 8);

    run_frame(3, 1);

    // Second START during data byte 2 is dropped.
    tx_delay = 10;
    prev     = done_cnt;
    base     = n_bytes;
    push_frame(3);
    pulse_start(3);
    wait_bytes(base + 4);
    pulse_start(7);
    wait_done(prev);

    // Reset while byte 4 is in flight, then a clean frame.
    base = n_bytes;
    eq.push_back('{8'hFE, 1});
    eq.push_back('{8'h03, 1});
    eq.push_back('{8'h00, 3});
    eq.push_back('{8'h04, 1});
    aq.push_back(0);
    pulse_start(3);
    wait_bytes(base + 4);
    tick(2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_bytes", eq.size(), 0);
    check("midrst_reads", aq.size(), 0);
    tick(20);
    check("midrst_quiet", n_bytes, base + 4);
    run_frame(3, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
